// File: rtl/data_queue_write_arbiter.sv
// Round-robin packet arbiter for the single write port of a data_queue.
// Whole packets are granted; over-long packets are truncated and the tail drained.
module data_queue_write_arbiter #(
  parameter int unsigned NUM_REQ            = 4,
  parameter int unsigned DATA_WIDTH         = 8,
  parameter int unsigned MAX_ELEMENT_LENGTH = 2047
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]            i_req_last,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic [NUM_REQ-1:0]            o_grant,
  output logic                          o_write_en,
  output logic [DATA_WIDTH-1:0]         o_data,
  output logic                          o_write_last,
  input  logic                          i_queue_full,
  output logic                          o_overlength
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW = $clog2(MAX_ELEMENT_LENGTH + 1);
  localparam logic [CW-1:0] CNT_TRUNC = CW'(MAX_ELEMENT_LENGTH - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_REQ - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_XFER  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]      gidx_q,  gidx_d;
  logic [IW-1:0]      rr_q,    rr_d;
  logic [CW-1:0]      cnt_q,   cnt_d;

  logic [DATA_WIDTH-1:0] req_data_arr [NUM_REQ];
  logic                  g_valid;
  logic                  g_last;
  logic                  at_max;
  logic [IW-1:0]         rr_inc;
  logic                  pick_found;
  logic [IW-1:0]         pick_idx;
  int unsigned           cand;

  // Unpack the flat data bus into per-requester beats.
  always_comb begin : unpack_data
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      req_data_arr[k] = i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign g_valid = i_req_valid[gidx_q];
  assign g_last  = i_req_last[gidx_q];
  assign at_max  = (cnt_q == CNT_TRUNC);
  assign rr_inc  = (gidx_q == IDX_LAST) ? '0 : gidx_q + IW'(1);
  assign o_data  = req_data_arr[gidx_q];
  assign o_grant = grant_q;

  // First valid requester at or above the rr pointer, wrapping around.
  always_comb begin : arbitrate
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = 32'(rr_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!pick_found && i_req_valid[IW'(cand)]) begin
        pick_found = 1'b1;
        pick_idx   = IW'(cand);
      end
    end
  end

  // Next-state and beat-level outputs.
  always_comb begin : fsm_next
    state_d      = state_q;
    grant_d      = grant_q;
    gidx_d       = gidx_q;
    rr_d         = rr_q;
    cnt_d        = cnt_q;
    o_req_ready  = '0;
    o_write_en   = 1'b0;
    o_write_last = 1'b0;
    o_overlength = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_d = NUM_REQ'(1) << pick_idx;
          gidx_d  = pick_idx;
          cnt_d   = '0;
          state_d = ST_XFER;
        end
      end

      ST_XFER: begin
        o_req_ready = i_queue_full ? '0 : grant_q;
        if (g_valid && !i_queue_full) begin
          o_write_en   = 1'b1;
          o_write_last = g_last | at_max;
          o_overlength = at_max & ~g_last;
          cnt_d        = cnt_q + CW'(1);
          if (g_last) begin
            state_d = ST_IDLE;
            grant_d = '0;
            cnt_d   = '0;
            rr_d    = rr_inc;
          end else if (at_max) begin
            state_d = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        // Tail of a truncated packet is accepted and dropped.
        o_req_ready = grant_q;
        if (g_valid && g_last) begin
          state_d = ST_IDLE;
          grant_d = '0;
          cnt_d   = '0;
          rr_d    = rr_inc;
        end
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin : state_reg
    if (i_reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_data_queue_write_arbiter.sv
// Bench for data_queue_write_arbiter: packet-level model checked every cycle
// plus directed scenarios with literal expectations.
module tb_data_queue_write_arbiter;
  localparam int unsigned N    = 4;
  localparam int unsigned DW   = 8;
  localparam int unsigned MAXL = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      req_valid = '0;
  logic [N*DW-1:0]   req_data = '0;
  logic [N-1:0]      req_last = '0;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      grant;
  logic              write_en;
  logic [DW-1:0]     wdata;
  logic              write_last;
  logic              queue_full = 1'b0;
  logic              overlength;

  data_queue_write_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_ELEMENT_LENGTH(MAXL)) dut (
    .i_clk(clk), .i_reset(rst), .i_req_valid(req_valid), .i_req_data(req_data),
    .i_req_last(req_last), .o_req_ready(req_ready), .o_grant(grant),
    .o_write_en(write_en), .o_data(wdata), .o_write_last(write_last),
    .i_queue_full(queue_full), .o_overlength(overlength));

  always #5 clk = ~clk;

  int vec = 0;
  int miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int oh2i(input logic [N-1:0] g);
    for (int i = 0; i < int'(N); i++) if (g[i]) return i;
    return -1;
  endfunction

  // Per-requester packet sources: {last, data} beats, popped on handshake.
  logic [8:0] src_q [N][$];
  bit         acc [N];
  int         acc_cnt [N];

  always @(posedge clk) begin
    #1;
    for (int k = 0; k < int'(N); k++) begin
      if (rst) begin
        src_q[k].delete();
      end else if (acc[k] && src_q[k].size() > 0) begin
        void'(src_q[k].pop_front());
      end
      acc[k] = 1'b0;
      req_valid[k]          = !rst && src_q[k].size() > 0;
      req_data[k*DW +: DW]  = (src_q[k].size() > 0) ? src_q[k][0][7:0] : 8'h00;
      req_last[k]           = (src_q[k].size() > 0) ? src_q[k][0][8] : 1'b0;
    end
  end

  typedef struct { int cyc; int owner; logic [7:0] data; bit last; bit ovl; } wrec_t;
  typedef struct { int cyc; int owner; } grec_t;
  wrec_t wlog [$];
  grec_t glog [$];
  int    vrise [N];
  int    cyc = 0;
  logic [N-1:0] prev_valid = '0;
  logic [N-1:0] prev_grant = '0;

  // Packet-level model: owner (-1 idle), beats written, draining flag, rr pointer.
  int m_owner = -1, m_beats = 0, m_ptr = 0;
  bit m_drain = 1'b0;
  logic [N-1:0] eg, er;
  logic         ewe, ewl, eovl;
  logic [7:0]   ed;
  int           n_owner, n_beats, n_ptr, sel, nb;
  bit           n_drain;

  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < int'(N); k++) begin
      acc[k] = !rst && req_valid[k] && req_ready[k];
      if (acc[k]) acc_cnt[k]++;
      if (req_valid[k] && !prev_valid[k]) vrise[k] = cyc;
    end
    prev_valid = req_valid;
    if (write_en) wlog.push_back('{cyc, oh2i(grant), wdata, write_last, overlength});
    if (grant != '0 && prev_grant == '0) glog.push_back('{cyc, oh2i(grant)});
    prev_grant = grant;

    if (rst) begin
      m_owner = -1; m_beats = 0; m_ptr = 0; m_drain = 1'b0;
      check("reset_outs", 32'({grant, req_ready, write_en, write_last, overlength}), 32'd0);
    end else begin
      eg = '0; er = '0; ewe = 1'b0; ewl = 1'b0; eovl = 1'b0; ed = 8'h00;
      n_owner = m_owner; n_beats = m_beats; n_ptr = m_ptr; n_drain = m_drain;
      if (m_owner < 0) begin
        sel = -1;
        for (int i = 0; i < int'(N); i++)
          if (sel < 0 && req_valid[(m_ptr + i) % int'(N)]) sel = (m_ptr + i) % int'(N);
        if (sel >= 0) begin n_owner = sel; n_beats = 0; n_drain = 1'b0; end
      end else begin
        eg = N'(1) << m_owner;
        ed = req_data[m_owner*DW +: DW];
        if (m_drain) begin
          er = eg;
          if (req_valid[m_owner] && req_last[m_owner]) begin
            n_owner = -1; n_ptr = (m_owner + 1) % int'(N); n_drain = 1'b0; n_beats = 0;
          end
        end else begin
          er  = queue_full ? '0 : eg;
          ewe = req_valid[m_owner] && !queue_full;
          if (ewe) begin
            nb   = m_beats + 1;
            ewl  = req_last[m_owner] || nb == int'(MAXL);
            eovl = nb == int'(MAXL) && !req_last[m_owner];
            n_beats = nb;
            if (req_last[m_owner]) begin
              n_owner = -1; n_ptr = (m_owner + 1) % int'(N); n_beats = 0;
            end else if (eovl) begin
              n_drain = 1'b1;
            end
          end
        end
      end
      check("grant", 32'(grant), 32'(eg));
      check("req_ready", 32'(req_ready), 32'(er));
      check("write_en", 32'(write_en), 32'(ewe));
      check("write_last", 32'(write_last), 32'(ewl));
      check("overlength", 32'(overlength), 32'(eovl));
      if (ewe) check("data", 32'(wdata), 32'(ed));
      m_owner = n_owner; m_beats = n_beats; m_ptr = n_ptr; m_drain = n_drain;
    end
  end

  task automatic wait_idle(input int budget);
    int n = 0;
    bit done = 1'b0;
    while (!done && n < budget) begin
      @(negedge clk); #1;
      n++;
      done = (grant == '0);
      for (int k = 0; k < int'(N); k++) if (src_q[k].size() != 0) done = 1'b0;
    end
    check("idle_reached", 32'(done), 32'd1);
  endtask

  task automatic wait_writes(input int target, input int budget);
    int n = 0;
    while (wlog.size() < target && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check("writes_reached", 32'(wlog.size() >= target), 32'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  int wb, gb, ab;
  logic [7:0] bytev;
  logic [3:0] lastv, ovlv;

  initial begin : stim
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // Round robin: every requester holds two 2-beat packets.
    wb = wlog.size(); gb = glog.size();
    for (int p = 0; p < 2; p++)
      for (int r = 0; r < int'(N); r++) begin
        bytev = 8'(r*16 + p*2 + 1); src_q[r].push_back({1'b0, bytev});
        bytev = 8'(r*16 + p*2 + 2); src_q[r].push_back({1'b1, bytev});
      end
    wait_idle(200);
    check("rr_count", 32'(glog.size() - gb), 32'd8);
    for (int j = 0; j < 5; j++) check("rr_order", 32'(glog[gb+j].owner), 32'(j % 4));
    for (int j = 0; j < 16; j++)
      check("rr_data", 32'(wlog[wb+j].data), 32'(((j/2)%4)*16 + ((j/2)/4)*2 + (j%2) + 1));
    check("rr_span", 32'(wlog[wb+15].cyc - wlog[wb].cyc), 32'd22);

    // Single 3-beat packet from requester 0.
    wb = wlog.size(); gb = glog.size();
    src_q[0].push_back({1'b0, 8'hA1});
    src_q[0].push_back({1'b0, 8'hA2});
    src_q[0].push_back({1'b1, 8'hA3});
    wait_idle(50);
    check("p1_nwrites", 32'(wlog.size() - wb), 32'd3);
    check("p1_d0", 32'(wlog[wb].data), 32'hA1);
    check("p1_d1", 32'(wlog[wb+1].data), 32'hA2);
    check("p1_d2", 32'(wlog[wb+2].data), 32'hA3);
    lastv = {1'b0, wlog[wb+2].last, wlog[wb+1].last, wlog[wb].last};
    check("p1_last", 32'(lastv), 32'b0100);
    check("p1_owner", 32'(glog[gb].owner), 32'd0);
    check("p1_bubble", 32'(glog[gb].cyc - vrise[0]), 32'd1);
    check("p1_consec", 32'(wlog[wb+2].cyc - wlog[wb].cyc), 32'd2);

    // Requester 1 stalled by a full queue for 5 cycles mid-packet.
    wb = wlog.size();
    for (int b = 1; b <= 4; b++) begin
      bytev = 8'(16 + b); src_q[1].push_back({b == 4, bytev});
    end
    wait_writes(wb + 1, 50);
    @(posedge clk); #2 queue_full = 1'b1;
    repeat (5) begin
      @(negedge clk); #1;
      check("full_ready1", 32'(req_ready[1]), 32'd0);
      check("full_we", 32'(write_en), 32'd0);
    end
    @(posedge clk); #2 queue_full = 1'b0;
    wait_idle(50);
    check("full_nwrites", 32'(wlog.size() - wb), 32'd4);
    for (int b = 0; b < 4; b++) check("full_data", 32'(wlog[wb+b].data), 32'(17 + b));
    lastv = {wlog[wb+3].last, wlog[wb+2].last, wlog[wb+1].last, wlog[wb].last};
    check("full_last", 32'(lastv), 32'b1000);

    // Over-long packet: 7 beats with MAX_ELEMENT_LENGTH 4.
    wb = wlog.size(); ab = acc_cnt[2];
    for (int b = 1; b <= 7; b++) begin
      bytev = 8'(32 + b); src_q[2].push_back({b == 7, bytev});
    end
    wait_idle(60);
    check("ovl_nwrites", 32'(wlog.size() - wb), 32'd4);
    for (int b = 0; b < 4; b++) check("ovl_data", 32'(wlog[wb+b].data), 32'(33 + b));
    lastv = {wlog[wb+3].last, wlog[wb+2].last, wlog[wb+1].last, wlog[wb].last};
    ovlv  = {wlog[wb+3].ovl, wlog[wb+2].ovl, wlog[wb+1].ovl, wlog[wb].ovl};
    check("ovl_last", 32'(lastv), 32'b1000);
    check("ovl_pulse", 32'(ovlv), 32'b1000);
    check("ovl_accepted", 32'(acc_cnt[2] - ab), 32'd7);

    // Reset during beat 2 of a requester-3 packet.
    wb = wlog.size();
    for (int b = 1; b <= 4; b++) begin
      bytev = 8'(48 + b); src_q[3].push_back({b == 4, bytev});
    end
    wait_writes(wb + 1, 50);
    #1 rst = 1'b1;
    #1;
    check("rst_async", 32'({grant, req_ready, write_en, write_last, overlength}), 32'd0);
    check("rst_partial_last", 32'(wlog[wb].last), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    gb = glog.size();
    src_q[3].push_back({1'b0, 8'h35}); src_q[3].push_back({1'b1, 8'h36});
    src_q[0].push_back({1'b0, 8'h01}); src_q[0].push_back({1'b1, 8'h02});
    wait_idle(60);
    check("rst_winner", 32'(glog[gb].owner), 32'd0);
    check("rst_second", 32'(glog[gb+1].owner), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule

// File: doc/data_queue_write_arbiter.md
Name: data_queue_write_arbiter

Overview:
- Shares the single write port of a data_queue between NUM_REQ packet sources.
- Grants whole packets (elements) round-robin and never interleaves beats of different packets.
- Marks each element end for the queue and stalls on queue full.
- Enforces MAX_ELEMENT_LENGTH by truncating and draining over-long packets.
- Sits in the write clock domain directly in front of the queue write side.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, 8, beat width; matches the queue.
- MAX_ELEMENT_LENGTH, 2047, maximum beats per element written to the queue.

Ports:
- i_clk  in  1  write-side clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_req_valid  in  NUM_REQ  per-requester beat valid.
- i_req_data  in  NUM_REQ*DATA_WIDTH  per-requester beat data; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- i_req_last  in  NUM_REQ  per-requester last beat of packet.
- o_req_ready  out  NUM_REQ  per-requester beat accept.
- o_grant  out  NUM_REQ  one-hot owner of the write port; 0 when idle.
- o_write_en  out  1  queue write strobe.
- o_data  out  DATA_WIDTH  queue write data.
- o_write_last  out  1  final beat of the element; qualified by o_write_en.
- i_queue_full  in  1  queue cannot accept a beat this cycle.
- o_overlength  out  1  one-cycle pulse on a truncation beat.

Behaviour:
- Reset (async): state IDLE, o_grant=0, rr pointer=0 (requester 0 highest priority), beat counter=0. Combinational outputs resolve to o_req_ready=0, o_write_en=0, o_write_last=0, o_overlength=0.
- Beat transfer: occurs when i_req_valid[k] & o_req_ready[k].
- o_req_ready[k] = o_grant[k] & ((state==XFER & ~i_queue_full) | state==DRAIN).
- Datapath is combinational, zero latency:
  - o_write_en = state==XFER & i_req_valid[g] & ~i_queue_full.
  - o_data = i_req_data[g], where g is the granted index.
- IDLE:
  - If any i_req_valid is set, select the first set bit searching from the rr pointer upward with wrap.
  - Register o_grant and go to XFER. Grant becomes visible the next cycle (1-cycle arbitration bubble).
  - No requester gets ready in IDLE.
- XFER, per accepted beat:
  - counter += 1.
  - o_write_last=1 if i_req_last[g], or if counter==MAX_ELEMENT_LENGTH-1 before the increment.
- XFER exits:
  - Last accepted with i_req_last: go to IDLE, rr pointer = g+1 mod NUM_REQ, o_grant=0, counter=0.
  - Truncation (beat number MAX_ELEMENT_LENGTH accepted without i_req_last): o_write_last=1 and o_overlength=1 on that beat, then go to DRAIN.
- DRAIN:
  - Granted requester stays ready regardless of i_queue_full.
  - Beats are discarded (o_write_en=0).
  - On accepted i_req_last: go to IDLE with the same pointer/grant/counter update as a normal packet end.
- Backpressure and stalls:
  - i_queue_full high in XFER holds everything; no beat is lost or duplicated.
  - Granted requester dropping valid mid-packet stalls XFER indefinitely; grant is held.
- Single-beat packets (valid & last on the first beat) are legal: o_write_en=1 and o_write_last=1 on the same cycle.
- Other requesters' valid/last inputs are ignored while not granted.
- Counter width is clog2(MAX_ELEMENT_LENGTH+1) and never wraps.
- Reset mid-packet aborts immediately. The queue sees no o_write_last for the partial element; the queue is reset together with this block.

Test Plan:
- Single requester 0 sends a 3-beat packet 0xA1,0xA2,0xA3 with queue not full. The grant appears 1 cycle after valid, then 3 consecutive o_write_en with matching o_data, and o_write_last on 0xA3 only.
- Requesters 0..3 all present 2-beat packets continuously. Grant order is 0,1,2,3,0. There is exactly one idle cycle between packets and no interleaved beats.
- Requester 1 mid-packet with i_queue_full held for 5 cycles. o_req_ready[1]=0 and o_write_en=0 for those 5 cycles; the beat sequence resumes intact.
- MAX_ELEMENT_LENGTH=4, requester 2 sends 7 beats. 4 beats are written, the 4th with o_write_last=1 and o_overlength=1. Beats 5..7 are accepted but not written. IDLE follows after beat 7.
- Assert i_reset during beat 2 of a packet. All outputs go to 0 asynchronously. After release, requester 0 wins despite the previous owner being requester 3.
